scan_index_sequencer: RTL and testbench

Sequential channel-scan controller that sits directly upstream of the 3-to-8 one-hot decoder.
- Steps a registered channel index through the enabled channels of a mask, holding each channel for a programmable dwell time.
- The decoder turns the index into one-hot channel enables.
- Supports single-sweep and continuous (wrap-around) scanning, with start/stop control and completion pulses.

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_index_sequencer_if.sv | 39 +++
 rtl/scan_next_idx.sv | 35 +++
 rtl/scan_index_sequencer.sv | 135 +++++++++++++
 tb/tb_scan_index_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared constants and state type for the channel-scan sequencer.
package scan_pkg;

   localparam int DEF_IDX_W   = 3;
   localparam int DEF_DWELL_W = 8;
   localparam int DEF_N_CH    = 2 ** DEF_IDX_W;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage : scan_pkg

// File: rtl/scan_index_sequencer_if.sv
// scan_index_sequencer_if: control inputs and scan outputs of the sequencer.
// Optional macro SCAN_SWEEP_CNT_EN adds the 16-bit sweep_count output.
interface scan_index_sequencer_if #(
   parameter int IDX_W   = 3,
   parameter int DWELL_W = 8
);
   logic                  start;
   logic                  stop;
   logic                  continuous;
   logic [2**IDX_W-1:0]   ch_mask;
   logic [DWELL_W-1:0]    dwell;
   logic [IDX_W-1:0]      sel_idx;
   logic                  sel_valid;
   logic                  slot_done;
   logic                  sweep_done;
   logic                  busy;
`ifdef SCAN_SWEEP_CNT_EN
   logic [15:0]           sweep_count;
`endif

   // Controller side: drives the requests, observes the scan.
   modport master (
      output start, stop, continuous, ch_mask, dwell,
      input  sel_idx, sel_valid, slot_done, sweep_done, busy
`ifdef SCAN_SWEEP_CNT_EN
      , input sweep_count
`endif
   );

   // Sequencer side.
   modport slave (
      input  start, stop, continuous, ch_mask, dwell,
      output sel_idx, sel_valid, slot_done, sweep_done, busy
`ifdef SCAN_SWEEP_CNT_EN
      , output sweep_count
`endif
   );

endinterface : scan_index_sequencer_if

// File: rtl/scan_next_idx.sv
// scan_next_idx: finds the next enabled channel above idx and the lowest
// enabled channel of a mask. Purely combinational.
module scan_next_idx #(
   parameter int IDX_W = 3
) (
   input  logic [2**IDX_W-1:0] mask,
   input  logic [IDX_W-1:0]    idx,
   output logic [IDX_W-1:0]    next_idx,
   output logic                none_higher,
   output logic [IDX_W-1:0]    low_idx
);
   localparam int N = 2 ** IDX_W;

   logic [N-1:0] higher;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_higher
         assign higher[gi] = mask[gi] && (IDX_W'(gi) > idx);
      end
   endgenerate

   assign none_higher = ~|higher;

   // Priority search from the top so the lowest qualifying bit wins.
   always_comb begin
      next_idx = '0;
      low_idx  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (higher[i]) next_idx = IDX_W'(i);
         if (mask[i])   low_idx  = IDX_W'(i);
      end
   end

endmodule : scan_next_idx

// File: rtl/scan_index_sequencer.sv
// scan_index_sequencer: steps a registered channel index through the enabled
// channels of a mask, holding each for dwell+1 cycles, single or continuous.
// Optional macro SCAN_SWEEP_CNT_EN adds a saturating 16-bit sweep counter.
module scan_index_sequencer
   import scan_pkg::*;
#(
   parameter int IDX_W   = DEF_IDX_W,
   parameter int DWELL_W = DEF_DWELL_W
) (
   input  logic                   clk,
   input  logic                   rst,
   scan_index_sequencer_if.slave  bus
);
   localparam int N = 2 ** IDX_W;

   state_t               state_reg, state_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [DWELL_W-1:0]   cnt_reg, cnt_next;
   logic [N-1:0]         mask_reg, mask_next;
   logic [DWELL_W-1:0]   dwell_reg, dwell_next;
   logic                 cont_reg, cont_next;

   logic [N-1:0]         mask_sel;
   logic [IDX_W-1:0]     nxt_higher;
   logic                 none_higher;
   logic [IDX_W-1:0]     low_idx;
   logic                 slot_last;
   logic                 slot_done_int;
   logic                 sweep_done_int;

   // In IDLE the live mask picks the first channel; in SCAN the snapshot drives stepping.
   assign mask_sel = (state_reg == IDLE) ? bus.ch_mask : mask_reg;

   scan_next_idx #(.IDX_W(IDX_W)) u_next (
      .mask        (mask_sel),
      .idx         (idx_reg),
      .next_idx    (nxt_higher),
      .none_higher (none_higher),
      .low_idx     (low_idx)
   );

   assign slot_last      = (state_reg == SCAN) && (cnt_reg == '0);
   assign slot_done_int  = slot_last && !bus.stop;
   assign sweep_done_int = slot_done_int && none_higher;

`ifdef SCAN_SWEEP_CNT_EN
   logic [15:0] sweep_cnt_reg, sweep_cnt_next;
`endif

   // State and snapshot registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         mask_reg  <= '0;
         dwell_reg <= '0;
         cont_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         mask_reg  <= mask_next;
         dwell_reg <= dwell_next;
         cont_reg  <= cont_next;
      end
   end

   // Next-state logic: start acceptance, dwell countdown, slot advance and wrap.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      mask_next  = mask_reg;
      dwell_next = dwell_reg;
      cont_next  = cont_reg;
      case (state_reg)
         IDLE: begin
            // stop outranks start; an empty mask is not a valid request.
            if (!bus.stop && bus.start && (bus.ch_mask != '0)) begin
               state_next = SCAN;
               idx_next   = low_idx;
               cnt_next   = bus.dwell;
               mask_next  = bus.ch_mask;
               dwell_next = bus.dwell;
               cont_next  = bus.continuous;
            end
         end
         SCAN: begin
            if (bus.stop) begin
               state_next = IDLE;
            end else if (cnt_reg == '0) begin
               if (!none_higher) begin
                  idx_next = nxt_higher;
                  cnt_next = dwell_reg;
               end else if (cont_reg) begin
                  idx_next = low_idx;
                  cnt_next = dwell_reg;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef SCAN_SWEEP_CNT_EN
   // Sweep counter register.
   always_ff @(posedge clk) begin
      if (rst) sweep_cnt_reg <= '0;
      else     sweep_cnt_reg <= sweep_cnt_next;
   end

   // Clear on an accepted start, saturating increment on each sweep_done.
   always_comb begin
      sweep_cnt_next = sweep_cnt_reg;
      if (state_reg == IDLE && !bus.stop && bus.start && (bus.ch_mask != '0))
         sweep_cnt_next = '0;
      else if (sweep_done_int && (sweep_cnt_reg != 16'hFFFF))
         sweep_cnt_next = sweep_cnt_reg + 16'd1;
   end

   assign bus.sweep_count = sweep_cnt_reg;
`endif

   assign bus.sel_idx    = idx_reg;
   assign bus.sel_valid  = (state_reg == SCAN);
   assign bus.busy       = (state_reg == SCAN);
   assign bus.slot_done  = slot_done_int;
   assign bus.sweep_done = sweep_done_int;

endmodule : scan_index_sequencer

// File: tb/tb_scan_index_sequencer.sv
// tb_scan_index_sequencer: directed scans with a cycle-stamped expectation
// queue; the monitor pops one entry per cycle the DUT shows activity.
module tb_scan_index_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      int         cyc;
      logic [2:0] idx;
      logic       slot;
      logic       sweep;
   } exp_t;

   exp_t q[$];

   scan_index_sequencer_if #(.IDX_W(3), .DWELL_W(8)) bus ();

   scan_index_sequencer #(.IDX_W(3), .DWELL_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d required<20000", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares each active cycle against the head of the queue.
   always @(negedge clk) begin
      while (q.size() != 0 && q[0].cyc < cyc) begin
         tests++;
         fails++;
         $display("FAIL missed_output: got none expected cyc=%0d idx=%0d slot=%0b sweep=%0b",
                  q[0].cyc, q[0].idx, q[0].slot, q[0].sweep);
         void'(q.pop_front());
      end
      if (bus.sel_valid === 1'b1 || bus.slot_done === 1'b1 || bus.sweep_done === 1'b1) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: got cyc=%0d idx=%0d slot=%0b sweep=%0b expected nothing",
                     cyc, bus.sel_idx, bus.slot_done, bus.sweep_done);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc || e.idx !== bus.sel_idx || e.slot !== bus.slot_done ||
                e.sweep !== bus.sweep_done || bus.sel_valid !== 1'b1) begin
               fails++;
               $display("FAIL scan_cycle: got cyc=%0d idx=%0d v=%0b slot=%0b sweep=%0b expected cyc=%0d idx=%0d v=1 slot=%0b sweep=%0b",
                        cyc, bus.sel_idx, bus.sel_valid, bus.slot_done, bus.sweep_done,
                        e.cyc, e.idx, e.slot, e.sweep);
            end else begin
               $display("[TB] cyc=%0d idx=%0d slot=%0b sweep=%0b ok", cyc, bus.sel_idx,
                        bus.slot_done, bus.sweep_done);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick();
   endtask

   task automatic push_exp(input int c, input logic [2:0] idx, input logic slot, input logic sweep);
      exp_t e;
      e.cyc = c; e.idx = idx; e.slot = slot; e.sweep = sweep;
      q.push_back(e);
   endtask

   // Expected cycles for nsw complete sweeps starting at cycle base; returns next free cycle.
   task automatic push_scan(input int base, input logic [7:0] mask, input int dw,
                            input int nsw, output int t_end);
      int t;
      int hi;
      t = base;
      hi = 0;
      for (int i = 0; i < 8; i++) if (mask[i]) hi = i;
      for (int s = 0; s < nsw; s++)
         for (int ch = 0; ch < 8; ch++)
            if (mask[ch])
               for (int d = 0; d <= dw; d++) begin
                  push_exp(t, 3'(ch), d == dw, (d == dw) && (ch == hi));
                  t++;
               end
      t_end = t;
   endtask

   task automatic drive_start(input logic [7:0] mask, input logic [7:0] dw, input logic cont);
      bus.ch_mask = mask;
      bus.dwell = dw;
      bus.continuous = cont;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_busy"}, 32'(bus.busy), 32'd0);
      chk({name, "_valid"}, 32'(bus.sel_valid), 32'd0);
   endtask

   initial begin
      int k;
      int t_end;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.continuous = 1'b0;
      bus.ch_mask = '0;
      bus.dwell = '0;
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_idx", 32'(bus.sel_idx), 32'd0);
      chk("reset_pulses", {30'd0, bus.slot_done, bus.sweep_done}, 32'd0);
      chk_idle("reset");
      rst = 1'b0;
      tick();

      // Single sweep over channels 0,2,5,7, three cycles per slot.
      k = cyc;
      push_scan(k + 1, 8'b1010_0101, 2, 1, t_end);
      chk("sweep1_len", 32'(t_end - k - 1), 32'd12);
      drive_start(8'b1010_0101, 8'd2, 1'b0);
      wait_cyc(k + 13);
      chk_idle("sweep1_end");
      chk("sweep1_hold_idx", 32'(bus.sel_idx), 32'd7);
      tick();

      // Continuous wrap over channels 1 and 4, one-cycle slots; stop on a slot edge.
      k = cyc;
      push_scan(k + 1, 8'b0001_0010, 0, 4, t_end);
      push_exp(k + 9, 3'd1, 1'b0, 1'b0);
      drive_start(8'b0001_0010, 8'd0, 1'b1);
      wait_cyc(k + 9);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      chk_idle("cont_stop");
      tick();

      // Zero mask is ignored, then a single-channel sweep on channel 7.
      drive_start(8'h00, 8'd3, 1'b0);
      chk_idle("zero_mask");
      tick();
      chk_idle("zero_mask_late");
      k = cyc;
      push_exp(k + 1, 3'd7, 1'b0, 1'b0);
      push_exp(k + 2, 3'd7, 1'b1, 1'b1);
      drive_start(8'h80, 8'd1, 1'b0);
      wait_cyc(k + 3);
      chk_idle("ch7_end");
      tick();

      // Stop four cycles into a long slot.
      k = cyc;
      for (int i = 1; i <= 4; i++) push_exp(k + i, 3'd0, 1'b0, 1'b0);
      drive_start(8'hFF, 8'd5, 1'b0);
      wait_cyc(k + 4);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      chk_idle("stop_mid");
      tick();

      // start together with stop in IDLE.
      bus.stop = 1'b1;
      drive_start(8'hFF, 8'd0, 1'b1);
      bus.stop = 1'b0;
      chk_idle("start_stop_same");
      tick();
      chk_idle("start_stop_after");

      // Start during a scan is ignored.
      k = cyc;
      push_exp(k + 1, 3'd2, 1'b0, 1'b0);
      push_exp(k + 2, 3'd2, 1'b1, 1'b0);
      push_exp(k + 3, 3'd3, 1'b0, 1'b0);
      push_exp(k + 4, 3'd3, 1'b1, 1'b1);
      drive_start(8'h0C, 8'd1, 1'b0);
      wait_cyc(k + 2);
      drive_start(8'hFF, 8'd7, 1'b1);
      wait_cyc(k + 5);
      chk_idle("midscan_start_end");
      chk("midscan_hold_idx", 32'(bus.sel_idx), 32'd3);
      tick();

      // Reset in the middle of a slot.
      k = cyc;
      for (int i = 1; i <= 3; i++) push_exp(k + i, 3'd6, 1'b0, 1'b0);
      drive_start(8'h40, 8'd9, 1'b0);
      wait_cyc(k + 3);
      rst = 1'b1;
      tick();
      chk("rst_mid_idx", 32'(bus.sel_idx), 32'd0);
      chk("rst_mid_pulses", {30'd0, bus.slot_done, bus.sweep_done}, 32'd0);
      chk_idle("rst_mid");
      rst = 1'b0;
      tick();

`ifdef SCAN_SWEEP_CNT_EN
      // Sweep counter: one increment per cycle on a single channel, cleared by a new start.
      k = cyc;
      for (int i = 1; i <= 5; i++) push_exp(k + i, 3'd0, 1'b1, 1'b1);
      push_exp(k + 6, 3'd0, 1'b0, 1'b0);
      drive_start(8'h01, 8'd0, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         wait_cyc(k + i);
         chk("sweep_count_inc", 32'(bus.sweep_count), 32'(i - 1));
      end
      wait_cyc(k + 6);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      chk("sweep_count_stop", 32'(bus.sweep_count), 32'd5);
      k = cyc;
      push_exp(k + 1, 3'd0, 1'b1, 1'b1);
      drive_start(8'h01, 8'd0, 1'b0);
      chk("sweep_count_clear", 32'(bus.sweep_count), 32'd0);
      tick();
      chk("sweep_count_after", 32'(bus.sweep_count), 32'd1);
      tick();
`endif

      repeat (3) tick();
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_scan_index_sequencer
